// File: rtl/mem_bridge_pkg.sv
// Shared constants and types for the MEM-stage memory bridge.
// MEM_BRIDGE_TIMEOUT_EN uses TIMEOUT_LIMIT to bound device accesses.
package mem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [31:0] DEV_BASE_DEF  = 32'h0000_7F00;
  localparam int unsigned DEV_WORDS_DEF = 8;
  localparam logic [31:0] DM_TOP_DEF    = 32'h0000_2000;
  localparam logic [7:0]  TIMEOUT_LIMIT = 8'd255;

endpackage

// File: rtl/mem_bridge_addr_decode.sv
// Combinational address decode into the data-memory and device windows.
module addr_decode #(
  parameter logic [31:0] DEV_BASE  = 32'h0000_7F00,
  parameter int unsigned DEV_WORDS = 8,
  parameter logic [31:0] DM_TOP    = 32'h0000_2000
) (
  input  logic [31:0] addr_i,
  output logic        dm_hit_o,
  output logic        dev_hit_o
);

  // 33-bit end bound so a window touching the top of memory does not wrap.
  localparam logic [32:0] DEV_END = {1'b0, DEV_BASE} + (33'(DEV_WORDS) << 2);

  assign dm_hit_o  = addr_i < DM_TOP;
  assign dev_hit_o = (addr_i >= DEV_BASE) && ({1'b0, addr_i} < DEV_END);

endmodule

// File: rtl/mem_bridge.sv
// MEM-stage bridge: zero-latency data memory, stalling handshake to a device window.
// Optional MEM_BRIDGE_TIMEOUT_EN aborts device accesses that never get an ack.
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter logic [31:0] DEV_BASE  = DEV_BASE_DEF,
  parameter int unsigned DEV_WORDS = DEV_WORDS_DEF,
  parameter logic [31:0] DM_TOP    = DM_TOP_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  input  logic        we_i,
  input  logic        re_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        dm_we_o,
  output logic [3:0]  dm_be_o,
  input  logic [31:0] dm_rdata_i,
  output logic        dev_req_o,
  output logic        dev_we_o,
  output logic [31:0] dev_addr_o,
  output logic [31:0] dev_wdata_o,
  output logic [3:0]  dev_be_o,
  input  logic        dev_ack_i,
  input  logic [31:0] dev_rdata_i,
  output logic        err_o
);

  state_e      state_q, state_d;
  logic [31:0] devAddr_q, devAddr_d;
  logic [31:0] devWdata_q, devWdata_d;
  logic [3:0]  devBe_q, devBe_d;
  logic        devWe_q, devWe_d;
  logic [31:0] capRdata_q, capRdata_d;
  logic        err_q, err_d;
  logic        dmHit, devHit, access, unmapped;
`ifdef MEM_BRIDGE_TIMEOUT_EN
  logic [7:0]  timeoutCnt_q, timeoutCnt_d;
`endif

  addr_decode #(
    .DEV_BASE (DEV_BASE),
    .DEV_WORDS(DEV_WORDS),
    .DM_TOP   (DM_TOP)
  ) u_decode (
    .addr_i   (addr_i),
    .dm_hit_o (dmHit),
    .dev_hit_o(devHit)
  );

  assign access   = we_i | re_i;
  assign unmapped = access & ~dmHit & ~devHit;

  always_comb begin
    state_d    = state_q;
    devAddr_d  = devAddr_q;
    devWdata_d = devWdata_q;
    devBe_d    = devBe_q;
    devWe_d    = devWe_q;
    capRdata_d = capRdata_q;
    err_d      = err_q | unmapped;
`ifdef MEM_BRIDGE_TIMEOUT_EN
    timeoutCnt_d = timeoutCnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (devHit && access) begin
          state_d    = REQ;
          devAddr_d  = addr_i;
          devWdata_d = wdata_i;
          devBe_d    = be_i;
          devWe_d    = we_i;
`ifdef MEM_BRIDGE_TIMEOUT_EN
          timeoutCnt_d = '0;
`endif
        end
      end
      REQ: begin
        if (dev_ack_i) begin
          state_d    = DONE;
          capRdata_d = dev_rdata_i;
        end
`ifdef MEM_BRIDGE_TIMEOUT_EN
        // The counter reaching LIMIT-1 marks the LIMIT-th cycle spent in REQ.
        else if (timeoutCnt_q == TIMEOUT_LIMIT - 8'd1) begin
          state_d    = DONE;
          capRdata_d = 32'hFFFF_FFFF;
          err_d      = 1'b1;
        end else begin
          timeoutCnt_d = timeoutCnt_q + 8'd1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      devAddr_q  <= '0;
      devWdata_q <= '0;
      devBe_q    <= '0;
      devWe_q    <= 1'b0;
      capRdata_q <= '0;
      err_q      <= 1'b0;
`ifdef MEM_BRIDGE_TIMEOUT_EN
      timeoutCnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      devAddr_q  <= devAddr_d;
      devWdata_q <= devWdata_d;
      devBe_q    <= devBe_d;
      devWe_q    <= devWe_d;
      capRdata_q <= capRdata_d;
      err_q      <= err_d;
`ifdef MEM_BRIDGE_TIMEOUT_EN
      timeoutCnt_q <= timeoutCnt_d;
`endif
    end
  end

  // Stall drops in DONE so the held MEM-stage access retires exactly once.
  always_comb begin
    stall_o = ((state_q == IDLE) && devHit && access) || (state_q == REQ);
    dm_we_o = we_i & dmHit;
    dm_be_o = dmHit ? be_i : 4'h0;
    if ((state_q == DONE) && !devWe_q) begin
      rdata_o = capRdata_q;
    end else if (dmHit) begin
      rdata_o = dm_rdata_i;
    end else begin
      rdata_o = '0;
    end
  end

  assign dev_req_o   = (state_q == REQ);
  assign dev_we_o    = devWe_q;
  assign dev_addr_o  = devAddr_q;
  assign dev_wdata_o = devWdata_q;
  assign dev_be_o    = devBe_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_mem_bridge.sv
// Directed self-checking bench for mem_bridge; define MEM_BRIDGE_TIMEOUT_EN to add the timeout case.
module tb_mem_bridge;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] addr_i, wdata_i, dm_rdata_i, dev_rdata_i;
  logic [3:0]  be_i;
  logic        we_i, re_i, dev_ack_i;
  logic [31:0] rdata_o, dev_addr_o, dev_wdata_o;
  logic [3:0]  dm_be_o, dev_be_o;
  logic        stall_o, dm_we_o, dev_req_o, dev_we_o, err_o;

  int testsRun = 0;
  int testsFailed = 0;

  mem_bridge dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .be_i       (be_i),
    .we_i       (we_i),
    .re_i       (re_i),
    .rdata_o    (rdata_o),
    .stall_o    (stall_o),
    .dm_we_o    (dm_we_o),
    .dm_be_o    (dm_be_o),
    .dm_rdata_i (dm_rdata_i),
    .dev_req_o  (dev_req_o),
    .dev_we_o   (dev_we_o),
    .dev_addr_o (dev_addr_o),
    .dev_wdata_o(dev_wdata_o),
    .dev_be_o   (dev_be_o),
    .dev_ack_i  (dev_ack_i),
    .dev_rdata_i(dev_rdata_i),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic w, input logic r,
                               input logic [31:0] wd, input logic [3:0] b);
    addr_i  = a;
    we_i    = w;
    re_i    = r;
    wdata_i = wd;
    be_i    = b;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One device access; ack is raised in REQ cycle number ackDelay+1 (ackDelay 0 = first REQ cycle).
  task automatic devAccess(input string tag, input logic [31:0] a, input logic w, input logic r,
                           input logic [31:0] wd, input logic [3:0] b, input int ackDelay,
                           input logic [31:0] ackData, input logic [31:0] expRdata, input int expStall);
    int stallCycles = 0;
    int reqCycles = 0;
    bit done = 0;
    applyStimulus(a, w, r, wd, b);
    for (int c = 0; c < 300 && !done; c++) begin
      #1;
      if (dev_req_o) begin
        reqCycles++;
        if (reqCycles == 1 || dev_ack_i === 1'b0) begin
          checkOutput({tag, " dev_addr"}, dev_addr_o, a);
          checkOutput({tag, " dev_we"}, 32'(dev_we_o), 32'(w));
          checkOutput({tag, " dev_wdata"}, dev_wdata_o, wd);
          checkOutput({tag, " dev_be"}, 32'(dev_be_o), 32'(b));
        end
      end
      if (stall_o) begin
        stallCycles++;
      end else if (c > 0) begin
        done = 1;
        if (!w) checkOutput({tag, " rdata in DONE"}, rdata_o, expRdata);
        checkOutput({tag, " dev_req in DONE"}, 32'(dev_req_o), 32'd0);
        checkOutput({tag, " dev_addr in DONE"}, dev_addr_o, a);
        checkOutput({tag, " stall cycles"}, 32'(stallCycles), 32'(expStall));
        applyStimulus(32'h0, 1'b0, 1'b0, 32'h0, 4'h0);
      end
      dev_ack_i   = dev_req_o && (reqCycles == ackDelay + 1);
      dev_rdata_i = dev_ack_i ? ackData : 32'h0BAD_0BAD;
      tick();
    end
    dev_ack_i = 1'b0;
    if (!done) checkOutput({tag, " reached DONE"}, 32'd0, 32'd1);
  endtask

  logic [31:0] decAddr  [6] = '{32'h0000_1FFC, 32'h0000_7F00, 32'h0000_7F1C,
                                32'h0000_7F20, 32'h0000_7EFC, 32'h0000_2000};
  logic        decStall [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic        decDm    [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    rst_i = 1'b1;
    applyStimulus(32'h0, 1'b0, 1'b0, 32'h0, 4'h0);
    dm_rdata_i  = 32'h0;
    dev_ack_i   = 1'b0;
    dev_rdata_i = 32'h0;
    tick();
    tick();
    checkOutput("reset dev_req", 32'(dev_req_o), 32'd0);
    checkOutput("reset dev_we", 32'(dev_we_o), 32'd0);
    checkOutput("reset dev_addr", dev_addr_o, 32'h0);
    checkOutput("reset dev_wdata", dev_wdata_o, 32'h0);
    checkOutput("reset dev_be", 32'(dev_be_o), 32'd0);
    checkOutput("reset err", 32'(err_o), 32'd0);
    checkOutput("reset stall", 32'(stall_o), 32'd0);
    rst_i = 1'b0;
    tick();

    // Data-memory load and store, zero added latency.
    applyStimulus(32'h0000_0010, 1'b0, 1'b1, 32'h0, 4'hF);
    dm_rdata_i = 32'h1234_5678;
    #1;
    checkOutput("dm load rdata", rdata_o, 32'h1234_5678);
    checkOutput("dm load stall", 32'(stall_o), 32'd0);
    checkOutput("dm load dm_we", 32'(dm_we_o), 32'd0);
    tick();
    checkOutput("dm load dev_req", 32'(dev_req_o), 32'd0);
    applyStimulus(32'h0000_0020, 1'b1, 1'b0, 32'h5555_AAAA, 4'h3);
    #1;
    checkOutput("dm store dm_we", 32'(dm_we_o), 32'd1);
    checkOutput("dm store dm_be", 32'(dm_be_o), 32'h3);
    checkOutput("dm store stall", 32'(stall_o), 32'd0);
    tick();
    checkOutput("dm store dev_req", 32'(dev_req_o), 32'd0);

    // Window edges, request withdrawn before the edge so no state changes.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(decAddr[i], 1'b0, 1'b1, 32'h0, 4'hF);
      #1;
      checkOutput($sformatf("decode %h stall", decAddr[i]), 32'(stall_o), 32'(decStall[i]));
      checkOutput($sformatf("decode %h dm_be", decAddr[i]), 32'(dm_be_o), decDm[i] ? 32'hF : 32'h0);
      checkOutput($sformatf("decode %h rdata", decAddr[i]), rdata_o, decDm[i] ? 32'h1234_5678 : 32'h0);
      applyStimulus(32'h0, 1'b0, 1'b0, 32'h0, 4'h0);
      tick();
    end
    checkOutput("decode leaves err clear", 32'(err_o), 32'd0);

    // Device accesses with different ack latencies.
    devAccess("dev store", 32'h0000_7F04, 1'b1, 1'b0, 32'hA5A5_0001, 4'hF, 1, 32'h1111_1111, 32'h0, 3);
    devAccess("dev load fast", 32'h0000_7F08, 1'b0, 1'b1, 32'h0, 4'hF, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2);
    devAccess("dev load slow", 32'h0000_7F1C, 1'b0, 1'b1, 32'h0, 4'h3, 3, 32'hCAFE_0123, 32'hCAFE_0123, 5);
    devAccess("dev we+re store", 32'h0000_7F10, 1'b1, 1'b1, 32'h0F0F_F0F0, 4'hC, 0, 32'h2222_2222, 32'h0, 2);
    checkOutput("err after device accesses", 32'(err_o), 32'd0);

    // Spurious ack in IDLE is ignored.
    dev_ack_i = 1'b1;
    tick();
    dev_ack_i = 1'b0;
    checkOutput("idle ack dev_req", 32'(dev_req_o), 32'd0);
    checkOutput("idle ack stall", 32'(stall_o), 32'd0);

    // Unmapped load: no stall, no strobes, err next cycle and sticky.
    applyStimulus(32'h0000_9000, 1'b0, 1'b1, 32'h0, 4'hF);
    #1;
    checkOutput("unmapped rdata", rdata_o, 32'h0);
    checkOutput("unmapped stall", 32'(stall_o), 32'd0);
    checkOutput("unmapped dm_be", 32'(dm_be_o), 32'd0);
    checkOutput("unmapped err before edge", 32'(err_o), 32'd0);
    tick();
    checkOutput("unmapped err", 32'(err_o), 32'd1);
    checkOutput("unmapped dev_req", 32'(dev_req_o), 32'd0);
    applyStimulus(32'h0000_9000, 1'b1, 1'b0, 32'h1, 4'hF);
    #1;
    checkOutput("unmapped store dm_we", 32'(dm_we_o), 32'd0);
    applyStimulus(32'h0, 1'b0, 1'b0, 32'h0, 4'h0);
    tick();
    tick();
    checkOutput("err sticky", 32'(err_o), 32'd1);

    // Reset in the middle of REQ abandons the access.
    applyStimulus(32'h0000_7F14, 1'b1, 1'b0, 32'h7777_0000, 4'hF);
    tick();
    checkOutput("pre-reset dev_req", 32'(dev_req_o), 32'd1);
    rst_i = 1'b1;
    applyStimulus(32'h0, 1'b0, 1'b0, 32'h0, 4'h0);
    tick();
    checkOutput("mid-REQ reset dev_req", 32'(dev_req_o), 32'd0);
    checkOutput("mid-REQ reset dev_addr", dev_addr_o, 32'h0);
    checkOutput("mid-REQ reset err", 32'(err_o), 32'd0);
    rst_i = 1'b0;
    dev_ack_i = 1'b1;
    dev_rdata_i = 32'h9999_9999;
    tick();
    dev_ack_i = 1'b0;
    checkOutput("post-reset ack dev_req", 32'(dev_req_o), 32'd0);
    checkOutput("post-reset ack stall", 32'(stall_o), 32'd0);
    checkOutput("post-reset ack dev_we", 32'(dev_we_o), 32'd0);
    devAccess("post-reset load", 32'h0000_7F00, 1'b0, 1'b1, 32'h0, 4'hF, 0, 32'h0BEE_F00D, 32'h0BEE_F00D, 2);

`ifdef MEM_BRIDGE_TIMEOUT_EN
    devAccess("timeout load", 32'h0000_7F0C, 1'b0, 1'b1, 32'h0, 4'hF, 1000, 32'h0, 32'hFFFF_FFFF, 256);
    checkOutput("timeout err", 32'(err_o), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
